adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_pkg.sv | 15 +
 rtl/b16_adder.sv | 11 +
 rtl/adder_arb.sv | 95 +++++++++
 tb/tb_adder_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared state encodings and id width for adder_arb
package adder_arb_pkg;

    localparam int ID_W   = 1;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/b16_adder.sv
// rtl/b16_adder.sv - 16-bit adder with carry out
module b16_adder (
    output logic [15:0] sum,
    output logic        carry,
    input  logic [15:0] a,
    input  logic [15:0] b
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arb.sv
// rtl/adder_arb.sv - two-requester arbiter sharing one 16-bit adder
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_carry,
    input  logic        rsp_ready
);

    state_t      state;
    req_id_t     last_grant;
    req_id_t     grant;
    req_id_t     op_id;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] add_sum;
    logic        add_carry;
    logic        accept;

    // On a tie, round-robin favours whoever did not win the last accepted grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = !rst && (state == IDLE) && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    b16_adder u_adder (
        .sum   (add_sum),
        .carry (add_carry),
        .a     (op_a),
        .b     (op_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            op_a       <= 16'h0000;
            op_b       <= 16'h0000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= 16'h0000;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant ? req1_a : req0_a;
                        op_b       <= grant ? req1_b : req0_b;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_carry <= add_carry;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arb.sv
// tb/tb_adder_arb.sv - randomized and directed self-checking bench for adder_arb
module tb_adder_arb;
    import adder_arb_pkg::*;

    logic clk;
    logic rst;
    logic v0, v1, rsp_ready;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0] rdy0, rdy1, rv, rid, rc;
    logic [1:0][15:0] rs;

    int checks;
    int errors;
    int cyc;

    // transaction-level model: one pending result per DUT, visible from a given cycle
    logic        m_has [2];
    int          m_vis [2];
    req_id_t     m_id  [2];
    logic [16:0] m_res [2];
    logic [15:0] m_osum [2];
    logic        m_ocarry [2];
    req_id_t     m_oid [2];
    req_id_t     m_last [2];
    logic        ev, er0, er1, g;
    int          qd0 [$];
    int          qd1 [$];

    adder_arb #(.PRIO_FIXED(0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1[0]),
        .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_sum(rs[0]), .rsp_carry(rc[0]),
        .rsp_ready(rsp_ready)
    );

    adder_arb #(.PRIO_FIXED(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1[1]),
        .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_sum(rs[1]), .rsp_carry(rc[1]),
        .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_has[k]    = 1'b0;
                m_osum[k]   = 16'h0000;
                m_ocarry[k] = 1'b0;
                m_oid[k]    = 1'b0;
                m_last[k]   = 1'b1;
            end
            ev = m_has[k] && (cyc >= m_vis[k]);
            if (ev) begin
                m_osum[k]   = m_res[k][15:0];
                m_ocarry[k] = m_res[k][16];
                m_oid[k]    = m_id[k];
            end
            er0 = 1'b0;
            er1 = 1'b0;
            if (!rst && !m_has[k] && (v0 || v1)) begin
                if (v0 && v1) g = (k == 1) ? 1'b0 : ~m_last[k];
                else          g = v0 ? 1'b0 : 1'b1;
                er0 = v0 && !g;
                er1 = v1 && g;
            end
            chk($sformatf("d%0d_req0_ready", k), int'(rdy0[k]), int'(er0));
            chk($sformatf("d%0d_req1_ready", k), int'(rdy1[k]), int'(er1));
            chk($sformatf("d%0d_rsp_valid", k), int'(rv[k]), int'(ev));
            chk($sformatf("d%0d_rsp_id", k), int'(rid[k]), int'(m_oid[k]));
            chk($sformatf("d%0d_rsp_sum", k), int'(rs[k]), int'(m_osum[k]));
            chk($sformatf("d%0d_rsp_carry", k), int'(rc[k]), int'(m_ocarry[k]));
            if (!rst && rv[k] && rsp_ready) begin
                if (k == 0) qd0.push_back({14'd0, rc[k], rid[k], rs[k]});
                else        qd1.push_back({14'd0, rc[k], rid[k], rs[k]});
            end
            if (!rst) begin
                if (ev && rsp_ready) m_has[k] = 1'b0;
                if (er0 || er1) begin
                    m_has[k]  = 1'b1;
                    m_vis[k]  = cyc + 2;
                    m_id[k]   = er1;
                    m_res[k]  = er1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
                    m_last[k] = er1;
                end
            end
        end
        cyc++;
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!(rdy0[0] || rdy1[0]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(n < 20), 1);
        @(posedge clk); #1;
        v0 = 1'b0;
        v1 = 1'b0;
        a0 = 16'($urandom); b0 = 16'($urandom);
        a1 = 16'($urandom); b1 = 16'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rv[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_req(input int id, input logic [15:0] a, input logic [15:0] b,
                          input int exp_id, input int exp_sum, input int exp_c);
        int lat;
        rsp_ready = 1'b1;
        if (id == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
        else         begin v1 = 1'b1; a1 = a; b1 = b; end
        wait_accept();
        wait_rsp(lat);
        chk("rsp_latency_edges", lat, 2);
        chk("lit_rsp_id", int'(rid[0]), exp_id);
        chk("lit_rsp_sum", int'(rs[0]), exp_sum);
        chk("lit_rsp_carry", int'(rc[0]), exp_c);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int lat;
        int act;
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", int'(rv[0]), 0);
        chk("reset_rsp_sum", int'(rs[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(0, 16'h0003, 16'h0004, 0, 16'h0007, 0);
        do_req(1, 16'h0003, 16'hFFFF, 1, 16'h0002, 1);
        do_req(0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1);

        // both requesters held valid from reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qd0.delete(); qd1.delete();
        v0 = 1'b1; a0 = 16'h0300; b0 = 16'h0400;
        v1 = 1'b1; a1 = 16'h0001; b1 = 16'h0001;
        rsp_ready = 1'b1;
        n = 0;
        while ((qd0.size() < 4 || qd1.size() < 4) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("alternate_timeout", int'(n < 60), 1);
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            act = (i < qd0.size()) ? qd0[i] : -1;
            chk($sformatf("rr_order_%0d", i), act, (i % 2 == 0) ? 32'h0000_0700 : 32'h0001_0002);
            act = (i < qd1.size()) ? qd1[i] : -1;
            chk($sformatf("fixed_order_%0d", i), act, 32'h0000_0700);
        end

        // consumer stalls in RESP
        rsp_ready = 1'b0;
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        wait_accept();
        wait_rsp(lat);
        chk("stall_latency_edges", lat, 2);
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", int'(rv[0]), 1);
            chk("stall_rsp_sum", int'(rs[0]), 16'h2345);
            chk("stall_rsp_id", int'(rid[0]), 0);
            chk("stall_ready0", int'(rdy0[0]), 0);
            chk("stall_ready1", int'(rdy1[0]), 0);
        end
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", int'(rv[0]), 0);
        @(posedge clk); #1;

        // reset during CALC discards the transaction
        v0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0001;
        wait_accept();
        rst = 1'b1; v0 = 1'b1;
        #1;
        chk("rst_calc_valid", int'(rv[0]), 0);
        chk("rst_calc_sum", int'(rs[0]), 0);
        chk("rst_calc_carry", int'(rc[0]), 0);
        chk("rst_calc_id", int'(rid[0]), 0);
        chk("rst_calc_ready0", int'(rdy0[0]), 0);
        qd0.delete();
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_response", qd0.size(), 0);
        do_req(0, 16'h0003, 16'h0004, 0, 16'h0007, 0);

        // randomized traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
